branch_predict_unit: RTL and testbench

- Parametrised successor to the combinational branch-condition decoder: resolves RV32I conditional branches from ALU flags and adds a direct-mapped branch history table (BHT) of 2-bit saturating counters.
- Fetch stage issues a lookup and receives a registered taken/not-taken prediction one cycle later.
- Execute stage presents the resolved branch. The block computes the actual outcome, updates the BHT, flags mispredicts and keeps a saturating mispredict counter.

---
 rtl/branch_predict_unit.sv | 132 +++++++++++++
 tb/tb_branch_predict_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - RV32I branch resolver with 2-bit saturating BHT predictor
module branch_predict_unit #(
  parameter int          N        = 32,
  parameter int          IDX_W    = 6,
  parameter int          CNT_W    = 16,
  parameter logic [1:0]  INIT_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  input  logic [N-1:0]     lk_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [N-1:0]     res_pc,
  input  logic [2:0]       res_funct3,
  input  logic             res_pred_taken,
  input  logic             z_flag,
  input  logic             s_flag,
  input  logic             v_flag,
  input  logic             c_flag,
  output logic             res_out_valid,
  output logic             branch_taken,
  output logic             mispredict,
  output logic             illegal_br,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       r_bht [DEPTH];
  logic             r_pred_valid;
  logic             r_pred_taken;
  logic             r_res_out_valid;
  logic             r_branch_taken;
  logic             r_mispredict;
  logic             r_illegal_br;
  logic [CNT_W-1:0] r_mis_cnt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic             w_actual;
  logic             w_illegal;
  logic             w_mispredict;
  logic [1:0]       w_ctr_next;
  logic             w_unused_pc_bits;

  // Word-aligned index; upper PC bits alias onto the same entries.
  assign w_lk_idx  = lk_pc[IDX_W+1:2];
  assign w_res_idx = res_pc[IDX_W+1:2];
  assign w_unused_pc_bits = ^{lk_pc[N-1:IDX_W+2], lk_pc[1:0], res_pc[N-1:IDX_W+2], res_pc[1:0]};

  // Branch condition decode from rs1-rs2 flags; reserved funct3 never taken.
  always_comb begin
    w_actual  = 1'b0;
    w_illegal = 1'b0;
    case (res_funct3)
      3'b000:  w_actual = z_flag;
      3'b001:  w_actual = ~z_flag;
      3'b100:  w_actual = s_flag ^ v_flag;
      3'b101:  w_actual = ~(s_flag ^ v_flag);
      3'b110:  w_actual = ~c_flag;
      3'b111:  w_actual = c_flag;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_mispredict = ~w_illegal & (w_actual != res_pred_taken);

  // Saturating 2-bit counter step for the resolving entry.
  always_comb begin
    w_ctr_next = r_bht[w_res_idx];
    if (w_actual) begin
      if (r_bht[w_res_idx] != 2'b11) w_ctr_next = r_bht[w_res_idx] + 2'b01;
    end else begin
      if (r_bht[w_res_idx] != 2'b00) w_ctr_next = r_bht[w_res_idx] - 2'b01;
    end
  end

  // BHT storage: lookup reads the pre-update value, so no write-to-read bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_bht[i] <= INIT_CTR;
    end else if (res_valid && !w_illegal) begin
      r_bht[w_res_idx] <= w_ctr_next;
    end
  end

  // Fetch-side prediction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end else begin
      r_pred_valid <= lk_valid;
      r_pred_taken <= lk_valid & r_bht[w_lk_idx][1];
    end
  end

  // Execute-side resolution registers; cleared when no branch is resolving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_out_valid <= 1'b0;
      r_branch_taken  <= 1'b0;
      r_mispredict    <= 1'b0;
      r_illegal_br    <= 1'b0;
    end else begin
      r_res_out_valid <= res_valid;
      r_branch_taken  <= res_valid & w_actual;
      r_mispredict    <= res_valid & w_mispredict;
      r_illegal_br    <= res_valid & w_illegal;
    end
  end

  // Mispredict counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis_cnt <= '0;
    end else if (res_valid && w_mispredict && (r_mis_cnt != {CNT_W{1'b1}})) begin
      r_mis_cnt <= r_mis_cnt + 1'b1;
    end
  end

  assign pred_valid       = r_pred_valid;
  assign pred_taken       = r_pred_taken;
  assign res_out_valid    = r_res_out_valid;
  assign branch_taken     = r_branch_taken;
  assign mispredict       = r_mispredict;
  assign illegal_br       = r_illegal_br;
  assign mispredict_count = r_mis_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - randomized self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

  localparam int N     = 32;
  localparam int IDX_W = 6;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lk_valid = 1'b0;
  logic [N-1:0]     lk_pc = '0;
  logic             pred_valid, pred_taken;
  logic             res_valid = 1'b0;
  logic [N-1:0]     res_pc = '0;
  logic [2:0]       res_funct3 = '0;
  logic             res_pred_taken = 1'b0;
  logic             z_flag = 1'b0, s_flag = 1'b0, v_flag = 1'b0, c_flag = 1'b0;
  logic             res_out_valid, branch_taken, mispredict, illegal_br;
  logic [CNT_W-1:0] mispredict_count;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: counters held as plain integers 0..3, count as integer.
  int bht [64];
  int mcnt;

  branch_predict_unit #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W), .INIT_CTR(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
    .res_pred_taken(res_pred_taken),
    .z_flag(z_flag), .s_flag(s_flag), .v_flag(v_flag), .c_flag(c_flag),
    .res_out_valid(res_out_valid), .branch_taken(branch_taken),
    .mispredict(mispredict), .illegal_br(illegal_br),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int pc_idx(input logic [31:0] pc);
    return (pc / 4) % 64;
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return bht[pc_idx(pc)] >= 2;
  endfunction

  // RV32I comparison semantics expressed on the flags of rs1-rs2.
  function automatic bit model_taken(input int f3, input bit z, input bit s, input bit v, input bit c);
    bit lt, ltu;
    lt  = (s != v);
    ltu = !c;
    case (f3)
      0: return z;
      1: return !z;
      4: return lt;
      5: return !lt;
      6: return ltu;
      7: return !ltu;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    foreach (bht[i]) bht[i] = 1;
    mcnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pv"}, pred_valid, 0);
    check({tag, ".pt"}, pred_taken, 0);
    check({tag, ".rov"}, res_out_valid, 0);
    check({tag, ".bt"}, branch_taken, 0);
    check({tag, ".mp"}, mispredict, 0);
    check({tag, ".ill"}, illegal_br, 0);
    check({tag, ".cnt"}, mispredict_count, 0);
  endtask

  // One clock: drive inputs, predict outputs from the model, compare after the edge.
  task automatic cyc(input string tag, input bit lv, input logic [31:0] lpc,
                     input bit rv, input logic [31:0] rpc, input int f3, input bit rpt,
                     input bit z, input bit s, input bit v, input bit c);
    bit e_pt, e_bt, e_ill, e_mp;
    int k;
    lk_valid = lv; lk_pc = lpc;
    res_valid = rv; res_pc = rpc; res_funct3 = f3[2:0]; res_pred_taken = rpt;
    z_flag = z; s_flag = s; v_flag = v; c_flag = c;
    e_pt  = lv && model_pred(lpc);
    e_ill = rv && (f3 == 2 || f3 == 3);
    e_bt  = rv && !e_ill && model_taken(f3, z, s, v, c);
    e_mp  = rv && !e_ill && (e_bt != rpt);
    if (rv && !e_ill) begin
      k = pc_idx(rpc);
      if (e_bt) bht[k] = (bht[k] == 3) ? 3 : bht[k] + 1;
      else      bht[k] = (bht[k] == 0) ? 0 : bht[k] - 1;
    end
    if (e_mp && mcnt < CMAX) mcnt++;
    @(posedge clk);
    #1;
    check({tag, ".pv"}, pred_valid, lv);
    check({tag, ".pt"}, pred_taken, e_pt);
    check({tag, ".rov"}, res_out_valid, rv);
    check({tag, ".bt"}, branch_taken, e_bt);
    check({tag, ".mp"}, mispredict, e_mp);
    check({tag, ".ill"}, illegal_br, e_ill);
    check({tag, ".cnt"}, mispredict_count, mcnt);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc);
    cyc(tag, 1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all_zero("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    lookup("lk00", 32'h00);
    lookup("lk04", 32'h04);
    lookup("lkFC", 32'hFC);

    for (int i = 0; i < 3; i++)
      cyc("beq40", 0, 0, 1, 32'h40, 0, model_pred(32'h40), 1, 0, 0, 0);
    lookup("lk40", 32'h40);

    for (int f = 0; f < 8; f++)
      for (int fl = 0; fl < 16; fl++)
        cyc("sweep", fl[0], 32'h80, 1, 32'h80, f, model_pred(32'h80), fl[3], fl[2], fl[1], fl[0]);
    cyc("blt", 0, 0, 1, 32'h84, 4, 0, 0, 1, 0, 1);
    cyc("bltu", 0, 0, 1, 32'h84, 6, 0, 0, 0, 0, 0);
    cyc("bgeu", 0, 0, 1, 32'h84, 7, 1, 0, 0, 0, 0);
    cyc("ill3", 1, 32'h84, 1, 32'h84, 3, 1, 1, 1, 1, 1);
    lookup("lk84", 32'h84);

    cyc("same5", 1, 32'h14, 1, 32'h14, 0, 0, 1, 0, 0, 0);
    lookup("next5", 32'h14);
    lookup("alias114", 32'h114);
    cyc("train114a", 0, 0, 1, 32'h114, 1, 1, 1, 0, 0, 0);
    cyc("train114b", 0, 0, 1, 32'h114, 1, 0, 1, 0, 0, 0);
    lookup("alias14", 32'h14);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] lp, rp;
      lp = {$urandom_range(3, 0), 6'($urandom), 2'b00};
      rp = {$urandom_range(3, 0), 6'($urandom), 2'b00};
      cyc("rand", 1'($urandom), lp, 1'($urandom), rp, $urandom_range(7, 0), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 20; i++)
      cyc("sat", 1, 32'h40, 1, 32'h40, 0, 0, 1, 0, 0, 0);
    check("sat.final", mispredict_count, 15);

    lk_valid = 1'b1; lk_pc = 32'h40;
    res_valid = 1'b1; res_pc = 32'h40; res_funct3 = 3'b000; res_pred_taken = 1'b0; z_flag = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    check_all_zero("midrst_hold");
    rst_n = 1'b1;
    lookup("post40", 32'h40);
    lookup("post14", 32'h14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
